blink_pattern_seq: RTL and testbench



---
 rtl/blink_pkg.sv | 14 +
 rtl/blink_pattern_seq_if.sv | 30 +++
 rtl/blink_tick.sv | 24 ++
 rtl/blink_pattern_seq.sv | 121 ++++++++++++
 tb/tb_blink_pattern_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared types and default sizes for the LED pattern sequencer family.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_REP_W = 4;

endpackage

// File: rtl/blink_pattern_seq_if.sv
// Control/status bundle between a pattern sequencer and its host.
// Outputs are registered except busy, which decodes the state register.
interface blink_pattern_seq_if #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4
);
    localparam int STEP_W = $clog2(PAT_W);

    logic [15:0]       currentCount;
    logic [15:0]       mask;
    logic [PAT_W-1:0]  pattern_in;
    logic              load;
    logic              start;
    logic              stop;
    logic [REP_W-1:0]  repeat_count;
    logic              led;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] step;

    modport master (
        output currentCount, mask, pattern_in, load, start, stop, repeat_count,
        input  led, busy, done, step
    );

    modport slave (
        input  currentCount, mask, pattern_in, load, start, stop, repeat_count,
        output led, busy, done, step
    );
endinterface

// File: rtl/blink_tick.sv
// Step-rate tick: rising edge of OR(count & mask); tick is combinational, one clk wide.
// Edge detector runs continuously so no edge is lost across consumer state changes.
module blink_tick (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] count,
    input  logic [15:0] mask,
    output logic        tick
);
    logic level;
    logic prev_level;

    assign level = |(count & mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_level <= 1'b0;
        end else begin
            prev_level <= level;
        end
    end

    assign tick = level & ~prev_level;
endmodule

// File: rtl/blink_pattern_seq.sv
// Serial LED pattern player: one bit per masked-counter tick, replayed repeat_count+1 times.
// led updates on the edge that first samples the rising level; strobes are never back-pressured.
module blink_pattern_seq
    import blink_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int REP_W = DEF_REP_W
) (
    input logic                clk,
    input logic                rst_n,
    blink_pattern_seq_if.slave bus
);
    localparam int STEP_W = $clog2(PAT_W);

    logic              tick;
    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [REP_W-1:0]  reps_q, reps_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              last_q, last_d;
    logic              led_q, led_d;
    logic              done_q, done_d;
    logic              emit;

    blink_tick u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .count (bus.currentCount),
        .mask  (bus.mask),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            reps_q  <= '0;
            step_q  <= '0;
            last_q  <= 1'b0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            reps_q  <= reps_d;
            step_q  <= step_d;
            last_q  <= last_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        reps_d  = reps_q;
        step_d  = step_q;
        last_d  = last_q;
        led_d   = led_q;
        done_d  = done_q;
        emit    = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            led_d   = 1'b0;
            done_d  = 1'b0;
            step_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.load) begin
                        pat_d = bus.pattern_in;
                    end
                    if (bus.start) begin
                        state_d = ARM;
                        step_d  = '0;
                        reps_d  = bus.repeat_count;
                        last_d  = 1'b0;
                        done_d  = 1'b0;
                    end
                end
                ARM: begin
                    if (tick) begin
                        emit    = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick && last_q) begin
                        led_d   = 1'b0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (tick) begin
                        emit = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // last is set while emitting the final bit so that bit is held a full tick.
        if (emit) begin
            led_d = pat_q[step_q];
            if (step_q == STEP_W'(PAT_W - 1)) begin
                step_d = '0;
                if (reps_q == '0) begin
                    last_d = 1'b1;
                end else begin
                    reps_d = reps_q - REP_W'(1);
                end
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.done = done_q;
    assign bus.step = step_q;
    assign bus.busy = (state_q == ARM) || (state_q == RUN);
endmodule

// File: tb/tb_blink_pattern_seq.sv
// Scoreboard bench: expected output tuples {led,busy,done,step} are queued by stimulus
// and popped by a monitor each time the observed tuple changes.
module tb_blink_pattern_seq;
    logic clk;
    logic rst_n;

    blink_pattern_seq_if #(.PAT_W(8), .REP_W(4)) bus ();

    blink_pattern_seq #(.PAT_W(8), .REP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    localparam logic [7:0] PAT_A = 8'b1011_0001;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.currentCount = 16'h0000;
        forever begin
            @(posedge clk);
            #1 bus.currentCount = bus.currentCount + 16'h0001;
        end
    end

    // Monitor: every change in the observable tuple must match the next queued expectation.
    initial begin
        logic [5:0] prev, cur, e;
        prev = 6'd0;
        forever begin
            @(negedge clk);
            cur = {bus.led, bus.busy, bus.done, bus.step};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got led=%b busy=%b done=%b step=%0d, none expected",
                             cur[5], cur[4], cur[3], cur[2:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL sequence got led=%b busy=%b done=%b step=%0d, want led=%b busy=%b done=%b step=%0d",
                                 cur[5], cur[4], cur[3], cur[2:0], e[5], e[4], e[3], e[2:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input logic l, input logic b, input logic d, input logic [2:0] s);
        exp_q.push_back({l, b, d, s});
    endtask

    task automatic push_emits(input logic [7:0] pat, input int n);
        logic [2:0] s;
        for (int i = 0; i < n; i++) begin
            s = 3'((i + 1) % 8);
            push(pat[i % 8], 1'b1, 1'b0, s);
        end
    endtask

    task automatic play_expect(input logic [7:0] pat, input int reps);
        push(1'b0, 1'b1, 1'b0, 3'd0);
        push_emits(pat, 8 * (reps + 1));
        push(1'b0, 1'b0, 1'b1, 3'd0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) chk({name, "_timeout"}, 32'(bus.done), 32'd1);
    endtask

    task automatic wait_step(input string name, input logic [2:0] v, input int budget);
        int n = 0;
        while (!(bus.busy && bus.step == v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.busy && bus.step == v)) chk({name, "_timeout"}, 32'(bus.step), 32'(v));
    endtask

    task automatic pulse(input logic ld, input logic st, input logic sp);
        bus.load  = ld;
        bus.start = st;
        bus.stop  = sp;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        int n;
        rst_n            = 1'b0;
        bus.mask         = 16'h0001;
        bus.pattern_in   = PAT_A;
        bus.load         = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.repeat_count = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(bus.led), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_step", 32'(bus.step), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic playback, load and start together.
        play_expect(PAT_A, 0);
        pulse(1'b1, 1'b1, 1'b0);
        wait_done("basic", 100);
        chk("basic_busy_after", 32'(bus.busy), 32'd0);

        // Two passes; a load during RUN must not disturb playback.
        bus.repeat_count = 4'd1;
        play_expect(PAT_A, 1);
        pulse(1'b0, 1'b1, 1'b0);
        wait_step("repeat", 3'd3, 100);
        bus.pattern_in = 8'hFF;
        pulse(1'b1, 1'b0, 1'b0);
        bus.pattern_in = PAT_A;
        wait_done("repeat", 200);

        // Load in DONE is accepted.
        bus.repeat_count = 4'd0;
        bus.pattern_in   = 8'hFF;
        pulse(1'b1, 1'b0, 1'b0);
        play_expect(8'hFF, 0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_done("load_ff", 100);
        bus.pattern_in = PAT_A;
        pulse(1'b1, 1'b0, 1'b0);

        // start during RUN is ignored; stop after the 4th bit returns to IDLE.
        push(1'b0, 1'b1, 1'b0, 3'd0);
        push_emits(PAT_A, 4);
        push(1'b0, 1'b0, 1'b0, 3'd0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_step("stop", 3'd2, 100);
        pulse(1'b0, 1'b1, 1'b0);
        wait_step("stop", 3'd4, 100);
        pulse(1'b0, 1'b0, 1'b1);
        chk("stop_led", 32'(bus.led), 32'd0);
        chk("stop_done", 32'(bus.done), 32'd0);
        chk("stop_busy", 32'(bus.busy), 32'd0);

        // stop and start in the same cycle: stop wins.
        push(1'b0, 1'b1, 1'b0, 3'd0);
        push_emits(PAT_A, 1);
        push(1'b0, 1'b0, 1'b0, 3'd0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_step("stopstart", 3'd1, 100);
        pulse(1'b0, 1'b1, 1'b1);
        chk("stopstart_busy", 32'(bus.busy), 32'd0);

        // mask=0 never ticks; then bit 8 gives the step rate.
        bus.mask = 16'h0000;
        push(1'b0, 1'b1, 1'b0, 3'd0);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (1000) @(negedge clk);
        chk("nomask_busy", 32'(bus.busy), 32'd1);
        chk("nomask_led", 32'(bus.led), 32'd0);
        n = 0;
        while (bus.currentCount[8:0] >= 9'd200 && n < 600) begin
            @(negedge clk);
            n++;
        end
        push_emits(PAT_A, 8);
        push(1'b0, 1'b0, 1'b1, 3'd0);
        bus.mask = 16'h0100;
        wait_step("mask256", 3'd1, 1200);
        chk("mask256_first_tick_count", 32'(bus.currentCount[8:0]), 32'd257);
        wait_done("mask256", 6000);
        bus.mask = 16'h0001;

        // Asynchronous reset mid-run clears everything, including the pattern.
        push(1'b0, 1'b1, 1'b0, 3'd0);
        push_emits(PAT_A, 3);
        push(1'b0, 1'b0, 1'b0, 3'd0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_step("rst", 3'd3, 100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_led", 32'(bus.led), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_step", 32'(bus.step), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        play_expect(8'h00, 0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_done("zeros", 100);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
